// File: rtl/shift_register_n.sv
// rtl/shift_register_n.sv - universal WIDTH-bit shift register with serial I/O and shift counter
// Load, shift, rotate and clear operations; every output is registered.
module shift_register_n #(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    localparam int         CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    count,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_SHL   = 3'd2;
    localparam logic [2:0] MODE_SHR   = 3'd3;
    localparam logic [2:0] MODE_ROTL  = 3'd4;
    localparam logic [2:0] MODE_ROTR  = 3'd5;
    localparam logic [2:0] MODE_CLEAR = 3'd6;

    localparam logic [WIDTH-1:0] RV        = WIDTH'(RESET_VALUE);
    localparam logic [CW-1:0]    COUNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0]    COUNT_PRE = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             is_shift;

    always_comb begin
        q_d      = q_q;
        sout_d   = sout_q;
        count_d  = count_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        case (mode)
            MODE_LOAD: begin
                q_d     = d;
                count_d = '0;
            end
            MODE_SHL: begin
                q_d      = {q_q[WIDTH-2:0], sin};
                sout_d   = q_q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_d      = {sin, q_q[WIDTH-1:1]};
                sout_d   = q_q[0];
                is_shift = 1'b1;
            end
            MODE_ROTL: begin
                q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                sout_d   = q_q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_ROTR: begin
                q_d      = {q_q[0], q_q[WIDTH-1:1]};
                sout_d   = q_q[0];
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                q_d     = '0;
                sout_d  = 1'b0;
                count_d = '0;
            end
            default: ; // HOLD and the reserved encoding keep all state
        endcase
        // Counter saturates, so done can only fire on the WIDTH-1 -> WIDTH step
        if (is_shift) begin
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
            done_d = (count_q == COUNT_PRE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RV;
            sout_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            sout_q  <= sout_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign sout  = sout_q;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_shift_register_n.sv
// tb/tb_shift_register_n.sv - scoreboard bench for shift_register_n (WIDTH=8, RESET_VALUE=8'hA5)
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_shift_register_n;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic [3:0] count;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] q;
        logic       s;
        logic [3:0] c;
        logic       d;
    } exp_t;

    exp_t sb[$];

    shift_register_n #(.WIDTH(8), .RESET_VALUE(32'hA5)) dut (
        .clk(clk), .rst(rst), .mode(mode), .d(d), .sin(sin),
        .q(q), .sout(sout), .count(count), .done(done)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".q"}, 32'(q), 32'(e.q));
        chk({tag, ".sout"}, 32'(sout), 32'(e.s));
        chk({tag, ".count"}, 32'(count), 32'(e.c));
        chk({tag, ".done"}, 32'(done), 32'(e.d));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk_all("op", e);
        end
    end

    task automatic op(input logic [2:0] m, input logic [7:0] dd, input logic si,
                      input logic [7:0] eq, input logic es, input logic [3:0] ec, input logic ed);
        exp_t e;
        @(negedge clk);
        #1;
        mode = m;
        d    = dd;
        sin  = si;
        e.q = eq; e.s = es; e.c = ec; e.d = ed;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] shl_q[8]   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        logic       shl_s[8]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] rotl_q[8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic       rotl_s[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] post_q[8]  = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        logic       post_s[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t rexp;
        rexp.q = 8'hA5; rexp.s = 1'b0; rexp.c = 4'd0; rexp.d = 1'b0;

        // Reset with the clock stopped, then with edges while held
        #3;
        rst = 1'b1;
        #1;
        chk_all("rst_async", rexp);
        mode = 3'd1;
        d    = 8'h3C;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("rst_held", rexp);
        #1;
        mode = 3'd0;
        rst  = 1'b0;

        // Load / hold
        op(3'd1, 8'h3C, 1'b0, 8'h3C, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) op(3'd0, 8'hFF, 1'b1, 8'h3C, 1'b0, 4'd0, 1'b0);

        // Serial transmit
        op(3'd1, 8'h81, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            op(3'd2, 8'h00, 1'b0, shl_q[i], shl_s[i], 4'(i + 1), (i == 7));
        op(3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 4'd8, 1'b0);

        // Shift right, rotate left x8, rotate right
        op(3'd1, 8'h01, 1'b0, 8'h01, 1'b0, 4'd0, 1'b0);
        op(3'd3, 8'h00, 1'b1, 8'h80, 1'b1, 4'd1, 1'b0);
        op(3'd1, 8'h01, 1'b0, 8'h01, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            op(3'd4, 8'h00, 1'b0, rotl_q[i], rotl_s[i], 4'(i + 1), (i == 7));
        op(3'd5, 8'h00, 1'b0, 8'h80, 1'b1, 4'd8, 1'b0);

        // Clear and reserved mode
        op(3'd1, 8'h5A, 1'b0, 8'h5A, 1'b1, 4'd0, 1'b0);
        op(3'd6, 8'hFF, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
        op(3'd2, 8'hFF, 1'b1, 8'h01, 1'b0, 4'd1, 1'b0);
        op(3'd7, 8'hFF, 1'b1, 8'h01, 1'b0, 4'd1, 1'b0);
        op(3'd7, 8'h33, 1'b0, 8'h01, 1'b0, 4'd1, 1'b0);

        // Mid-sequence reset
        op(3'd1, 8'hF0, 1'b0, 8'hF0, 1'b0, 4'd0, 1'b0);
        op(3'd2, 8'h00, 1'b0, 8'hE0, 1'b1, 4'd1, 1'b0);
        op(3'd2, 8'h00, 1'b0, 8'hC0, 1'b1, 4'd2, 1'b0);
        op(3'd2, 8'h00, 1'b0, 8'h80, 1'b1, 4'd3, 1'b0);
        op(3'd2, 8'h00, 1'b0, 8'h00, 1'b1, 4'd4, 1'b0);
        op(3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 4'd5, 1'b0);
        @(negedge clk);
        #1;
        mode = 3'd0;
        #1;
        rst = 1'b1;
        #1;
        chk_all("rst_mid", rexp);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            op(3'd2, 8'h00, 1'b1, post_q[i], post_s[i], 4'(i + 1), (i == 7));
        op(3'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 4'd8, 1'b0);

        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
